// File: rtl/cpu_sequencer_if.sv
// Handshake/data bundle between the sequencer, instruction RAM and decode.
// master = environment side (drives RUN/STEP/EXTRA/RAM_Q); slave = sequencer side.
interface cpu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             RUN;
    logic             STEP;
    logic             EXTRA;
    logic [15:0]      RAM_Q;
    logic             FETCH;
    logic             EXEC1;
    logic             EXEC2;
    logic [3:0]       IR;
    logic [11:0]      N;
    logic             HALTED;
    logic             BUSY;
    logic [CNT_W-1:0] INSTR_CNT;

    modport master (
        output RUN, STEP, EXTRA, RAM_Q,
        input  FETCH, EXEC1, EXEC2, IR, N, HALTED, BUSY, INSTR_CNT
    );

    modport slave (
        input  RUN, STEP, EXTRA, RAM_Q,
        output FETCH, EXEC1, EXEC2, IR, N, HALTED, BUSY, INSTR_CNT
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer + instruction register; strobes decode straight from state (0 cycles),
// 2 or 3 cycles per instruction. No backpressure: STEP while busy/halted is dropped, RUN low only ends at a boundary.
module cpu_sequencer #(
    parameter logic [3:0] OPC_STP = 4'b0111,
    parameter int         CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC1 = 3'd2,
        S_EXEC2 = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             step_q, step_d;
    logic [3:0]       ir_q, ir_d;
    logic [11:0]      n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             bump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            step_q  <= 1'b0;
            ir_q    <= 4'h0;
            n_q     <= 12'h000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            ir_q    <= ir_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        ir_d    = ir_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        retire  = 1'b0;
        bump    = 1'b0;

        case (state_q)
            S_WAIT: begin
                // RUN has priority, so a simultaneous STEP never enters step mode
                if (bus.RUN) begin
                    state_d = S_FETCH;
                end else if (bus.STEP) begin
                    state_d = S_FETCH;
                    step_d  = 1'b1;
                end
            end
            S_FETCH: begin
                ir_d    = bus.RAM_Q[15:12];
                n_d     = bus.RAM_Q[11:0];
                state_d = S_EXEC1;
            end
            S_EXEC1: begin
                if (ir_q == OPC_STP) begin
                    state_d = S_HALT;
                    bump    = 1'b1;
                end else if (bus.EXTRA) begin
                    state_d = S_EXEC2;
                end else begin
                    retire = 1'b1;
                end
            end
            S_EXEC2: retire = 1'b1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_WAIT;
        endcase

        // Only a free-running sequencer chains straight into the next fetch
        if (retire) begin
            bump = 1'b1;
            if (bus.RUN && !step_q) begin
                state_d = S_FETCH;
            end else begin
                state_d = S_WAIT;
                step_d  = 1'b0;
            end
        end

        if (bump && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        bus.FETCH     = (state_q == S_FETCH);
        bus.EXEC1     = (state_q == S_EXEC1);
        bus.EXEC2     = (state_q == S_EXEC2);
        bus.BUSY      = (state_q == S_FETCH) || (state_q == S_EXEC1) || (state_q == S_EXEC2);
        bus.HALTED    = (state_q == S_HALT);
        bus.IR        = ir_q;
        bus.N         = n_q;
        bus.INSTR_CNT = cnt_q;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed + randomized bench for cpu_sequencer against an instruction-level reference model.
// A second instance with a 4-bit counter exercises counter saturation within a short run.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        step;
    logic        extra;
    logic [15:0] ram_q;

    int n_cmp = 0;
    int n_err = 0;

    cpu_sequencer_if #(.CNT_W(16)) bus ();
    cpu_sequencer_if #(.CNT_W(4))  bus_s ();

    assign bus.RUN     = run;
    assign bus.STEP    = step;
    assign bus.EXTRA   = extra;
    assign bus.RAM_Q   = ram_q;
    assign bus_s.RUN   = run;
    assign bus_s.STEP  = step;
    assign bus_s.EXTRA = extra;
    assign bus_s.RAM_Q = ram_q;

    cpu_sequencer #(.OPC_STP(4'b0111), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cpu_sequencer #(.OPC_STP(4'b0111), .CNT_W(4)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: position inside the current instruction (-1 = idle),
    // plus halt flag, single-step flag, latched word and retired counts.
    int         pos_m;
    bit         halted_m;
    bit         stepping_m;
    logic [3:0] ir_m;
    logic [11:0] n_m;
    int         cnt_m;
    int         cnt_s_m;

    function automatic void model_clear();
        pos_m      = -1;
        halted_m   = 1'b0;
        stepping_m = 1'b0;
        ir_m       = 4'h0;
        n_m        = 12'h000;
        cnt_m      = 0;
        cnt_s_m    = 0;
    endfunction

    function automatic void model_retire();
        if (cnt_m < 65535) cnt_m++;
        if (cnt_s_m < 15)  cnt_s_m++;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_edge();
        if (halted_m) return;
        if (pos_m < 0) begin
            if (run) begin
                pos_m = 0; stepping_m = 1'b0;
            end else if (step) begin
                pos_m = 0; stepping_m = 1'b1;
            end
        end else if (pos_m == 0) begin
            ir_m  = ram_q[15:12];
            n_m   = ram_q[11:0];
            pos_m = 1;
        end else if (pos_m == 1 && ir_m == 4'h7) begin
            model_retire();
            halted_m = 1'b1;
            pos_m    = -1;
        end else if (pos_m == 1 && extra) begin
            pos_m = 2;
        end else begin
            model_retire();
            if (run && !stepping_m) begin
                pos_m = 0;
            end else begin
                pos_m = -1; stepping_m = 1'b0;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("fetch",  32'(bus.FETCH),  32'(pos_m == 0));
        check("exec1",  32'(bus.EXEC1),  32'(pos_m == 1));
        check("exec2",  32'(bus.EXEC2),  32'(pos_m == 2));
        check("busy",   32'(bus.BUSY),   32'(pos_m >= 0));
        check("halted", 32'(bus.HALTED), 32'(halted_m));
        check("ir",     32'(bus.IR),     32'(ir_m));
        check("n",      32'(bus.N),      32'(n_m));
        check("cnt",    32'(bus.INSTR_CNT),   32'(cnt_m));
        check("cnt_s",  32'(bus_s.INSTR_CNT), 32'(cnt_s_m));
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Called at a negedge; asserts reset between edges and checks the async clear.
    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int hcnt;
        run = 1'b0; step = 1'b0; extra = 1'b0; ram_q = 16'h0000;
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        do_reset();

        // Free-run, 2-cycle instructions
        run = 1'b1; ram_q = 16'h8005; extra = 1'b0;
        tick();
        tick();
        check("ldi_ir", 32'(bus.IR), 32'h8);
        check("ldi_n",  32'(bus.N),  32'h005);
        repeat (6) tick();
        check("ldi_cnt", 32'(bus.INSTR_CNT), 32'd3);

        // Free-run, 3-cycle instructions
        ram_q = 16'h0123; extra = 1'b1;
        repeat (9) tick();
        check("ext_n", 32'(bus.N), 32'h123);

        // RUN dropped mid-instruction: finishes then idles
        run = 1'b0;
        repeat (4) tick();
        check("run_off_busy", 32'(bus.BUSY), 32'd0);

        // Single step, with a stray STEP during EXEC1
        do_reset();
        ram_q = 16'h2010; extra = 1'b1;
        step = 1'b1; tick();
        step = 1'b0; tick();
        check("step_exec1", 32'(bus.EXEC1), 32'd1);
        step = 1'b1; tick();
        step = 1'b0; tick();
        repeat (3) tick();
        check("step_cnt",  32'(bus.INSTR_CNT), 32'd1);
        check("step_idle", 32'(bus.BUSY),      32'd0);

        // STP halts; RUN/STEP toggling ignored; reset recovers
        do_reset();
        run = 1'b1; ram_q = 16'h7000; extra = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            run  = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            tick();
        end
        check("halt_flag", 32'(bus.HALTED),    32'd1);
        check("halt_cnt",  32'(bus.INSTR_CNT), 32'd1);
        step = 1'b0; run = 1'b0;
        do_reset();
        check("halt_rst_cnt", 32'(bus.INSTR_CNT), 32'd0);
        check("halt_rst_hlt", 32'(bus.HALTED),    32'd0);

        // Asynchronous reset in the middle of EXEC2
        run = 1'b1; ram_q = 16'h0123; extra = 1'b1;
        repeat (3) tick();
        check("pre_async_exec2", 32'(bus.EXEC2), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_exec2", 32'(bus.EXEC2), 32'd0);
        check("async_busy",  32'(bus.BUSY),  32'd0);
        check("async_ir",    32'(bus.IR),    32'd0);
        check("async_n",     32'(bus.N),     32'd0);
        check("async_cnt",   32'(bus.INSTR_CNT), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        hcnt = 0;
        run = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) run = ~run;
            step  = ($urandom_range(0, 4) == 0);
            extra = 1'($urandom_range(0, 1));
            ram_q = 16'($urandom);
            if (ram_q[15:12] == 4'h7 && $urandom_range(0, 7) != 0) ram_q[15:12] = 4'h9;
            tick();
            if (halted_m) hcnt++; else hcnt = 0;
            if (hcnt > 4) begin
                do_reset();
                hcnt = 0;
            end
        end

        // Counter saturation on the narrow instance
        run = 1'b0; step = 1'b0;
        do_reset();
        run = 1'b1; ram_q = 16'h8005; extra = 1'b0;
        repeat (42) tick();
        check("sat_cnt16", 32'(bus.INSTR_CNT),   32'd20);
        check("sat_cnt4",  32'(bus_s.INSTR_CNT), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Control sequencer and instruction register stage directly upstream of the instruction decoder.
- Generates the one-hot cycle strobes FETCH/EXEC1/EXEC2 consumed by decode.
- Latches the fetched 16-bit instruction word, presents opcode IR[3:0] and operand N[11:0], and samples decode's EXTRA to decide whether EXEC2 runs.
- Adds run/single-step control, STP halt handling and a retired-instruction counter.

Parameters:
- OPC_STP, 4'b0111, opcode that halts the sequencer.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- RUN  input  1  level; 1 = free-run instructions back to back.
- STEP  input  1  single-cycle pulse; executes exactly one instruction when RUN=0.
- EXTRA  input  1  from decode; valid during EXEC1; 1 = instruction needs EXEC2.
- RAM_Q  input  16  RAM read data; holds the instruction word during FETCH.
- FETCH  output  1  high for the fetch cycle.
- EXEC1  output  1  high for first execute cycle.
- EXEC2  output  1  high for second execute cycle.
- IR  output  4  opcode = latched word [15:12].
- N  output  12  operand = latched word [11:0].
- HALTED  output  1  high while in HALT state.
- BUSY  output  1  high in FETCH/EXEC1/EXEC2.
- INSTR_CNT  output  CNT_W  count of retired instructions, saturating.

Behaviour:
- Reset (async, rst_n=0): state=WAIT; FETCH=EXEC1=EXEC2=0; IR=0; N=0; HALTED=0; BUSY=0; INSTR_CNT=0. Reset overrides every state, including mid-instruction and HALT. After release, first clock edge evaluates WAIT.
- State register is one-hot or encoded. Strobe outputs decode directly from state; no extra latency. Exactly one of FETCH/EXEC1/EXEC2 is high when BUSY=1; all are low in WAIT and HALT.
- WAIT:
  - RUN=1 -> FETCH.
  - Else STEP=1 -> FETCH, and set internal step_mode=1.
  - Else stay.
- FETCH (1 cycle):
  - On the leaving edge, latch RAM_Q: IR<=RAM_Q[15:12], N<=RAM_Q[11:0].
  - Go to EXEC1 unconditionally.
  - IR/N are stable from EXEC1 through the end of the instruction.
- EXEC1:
  - IR==OPC_STP -> HALT; INSTR_CNT increments; EXTRA ignored.
  - Else EXTRA=1 -> EXEC2.
  - Else instruction retires: INSTR_CNT increments; next = FETCH if RUN=1 and step_mode=0, otherwise WAIT (clear step_mode).
- EXEC2: instruction retires: INSTR_CNT increments; same next-state rule as a retiring EXEC1.
- HALT: HALTED=1; RUN and STEP ignored; exit only via rst_n.
- RUN deasserted mid-instruction: the current instruction completes, then WAIT. No instruction is ever aborted except by reset.
- STEP while BUSY or HALTED: ignored, not queued.
- RUN=1 and STEP=1 together in WAIT: RUN wins; step_mode stays 0.
- INSTR_CNT saturates at all-ones and does not wrap.
- Throughput in free-run: 2 cycles for a non-EXTRA instruction, 3 cycles for an EXTRA instruction, no bubbles between instructions.

Test Plan:
- Reset then RUN=1, RAM_Q=16'h8005 (LDI 5), EXTRA=0 -> strobes FETCH,EXEC1,FETCH,...; IR=4'h8 and N=12'h005 from the first EXEC1; INSTR_CNT increments every 2 cycles.
- RUN=1, RAM_Q=16'h0123, EXTRA=1 in EXEC1 -> strobes FETCH,EXEC1,EXEC2 repeat every 3 cycles; N=12'h123; INSTR_CNT increments on each EXEC2 exit.
- RUN=0, pulse STEP once with RAM_Q=16'h2010, EXTRA=1 -> FETCH,EXEC1,EXEC2, then WAIT; INSTR_CNT=1; a second STEP pulse during EXEC1 has no effect.
- RUN=1, RAM_Q=16'h7000 (STP) -> FETCH,EXEC1, then HALTED=1 with all strobes 0; INSTR_CNT=1; RUN/STEP toggling keeps HALTED=1; rst_n pulse returns to WAIT with INSTR_CNT=0.
- Assert rst_n=0 asynchronously mid-EXEC2 (between edges) -> outputs clear immediately without a clock edge; IR=0, N=0.
- Preload counter near max (force or run 65535 instructions), run 3 more -> INSTR_CNT holds 16'hFFFF.
